averager_scheduler: RTL and testbench
=====================================

// Module: averager_scheduler
// PURPOSE
//  Sequences averager_counter through N back-to-back averaging runs per software start.
//  Drives the averager's restart/clken and waits for each run to finish (ready rising).
//  Captures n_avg per run and reports per-run and batch completion.
//  Sits between the register/control bus and the averager; software no longer polls ready.
// PARAMETERS
//  SLOW_COUNT_WIDTH  19  width of averager n_avg
//  RUN_COUNT_WIDTH   16  width of n_runs / run_count
//  TIMEOUT_WIDTH     32  width of watchdog counter (used only with AVG_SCHED_TIMEOUT_EN)
// PORTS
//  clk            in   1                 sole clock
//  rst            in   1                 asynchronous, active-high reset
//  start          in   1                 1-cycle request to begin a batch
//  abort          in   1                 1-cycle request to stop a batch
//  n_runs         in   RUN_COUNT_WIDTH   runs per batch, sampled on accepted start; 0 = continuous
//  avg_ready      in   1                 averager ready
//  avg_n_avg      in   SLOW_COUNT_WIDTH  averager n_avg
//  avg_restart    out  1                 restart request to averager
//  avg_clken      out  1                 clock enable to averager
//  busy           out  1                 high in any state except IDLE
//  run_count      out  RUN_COUNT_WIDTH   runs completed in the current batch
//  last_n_avg     out  SLOW_COUNT_WIDTH  n_avg captured at the most recent run end
//  run_done       out  1                 1-cycle pulse per completed run
//  done           out  1                 1-cycle pulse when the batch completes
//  timeout_cycles in   TIMEOUT_WIDTH     watchdog limit; 0 = disabled (macro only)
//  error          out  1                 sticky watchdog flag
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; the n_runs latch is 0.
//  All outputs are registered.
//  States:
//   IDLE: start -> latch n_runs, run_count<=0, error<=0, go ARM.
//   ARM: avg_restart=1 while in ARM. When avg_ready==0, go WAIT_READY.
//   WAIT_READY: avg_restart=0. When avg_ready==1 (sampled high):
//     last_n_avg<=avg_n_avg; run_count<=run_count+1; run_done pulse.
//     If run_count+1==n_runs latch, go DONE; otherwise go ARM.
//   DONE: done=1 for exactly 1 cycle, then go IDLE.
//  avg_clken = 1 in ARM, WAIT_READY and DONE; 0 in IDLE.
//  Latency: start accepted -> avg_restart high on the next cycle.
//  Final run-end sample -> done high 2 cycles later.
//  n_runs latch==0: runs repeat until abort; run_count wraps modulo 2^RUN_COUNT_WIDTH; done never fires.
//  start while busy is ignored.
//  abort in any non-IDLE state -> IDLE on the next cycle.
//   On abort: avg_restart drops, no done pulse; run_count and last_n_avg are held.
//  start and abort in the same cycle while IDLE: abort wins, nothing starts.
//  Run end and abort in the same cycle: abort wins; no run_done, counters are not updated.
//  rst mid-batch: immediate return to reset values, including avg_restart=0.
//  Reading avg_ready: it is only meaningful after ready has fallen.
//   ARM therefore never completes a run, even if ready is already high.
// CONFIGURATION
//  Macro AVG_SCHED_TIMEOUT_EN:
//   Defined:
//    Watchdog counter clears on entry to ARM and to WAIT_READY, and increments every cycle in those states.
//    If timeout_cycles!=0 and the counter equals timeout_cycles: error<=1 (sticky until next accepted start).
//    Timeout goes to IDLE with no done pulse and behaves like abort.
//   Not defined: timeout_cycles port absent; error tied to 0; no counter logic.
// STRUCTURE
//  Package avg_sched_pkg: state enum (IDLE, ARM, WAIT_READY, DONE); default width localparams.
//  Sub-module avg_sched_watchdog: clear/enable/limit -> expired.
//   Instantiated only under AVG_SCHED_TIMEOUT_EN.
//  Everything else lives in one FSM plus datapath registers in this module.
// TESTING
//  1. n_runs=3, averager model with 20-cycle runs, start pulse
//     -> 3 run_done pulses; run_count 1,2,3; done one pulse 2 cycles after the 3rd ready rise; busy falls with done.
//  2. Model n_avg=5,7,9 on successive runs
//     -> last_n_avg reads 5, then 7, then 9 after each run_done.
//  3. n_runs=0, let 4 runs complete, then abort
//     -> run_count=4; busy low on the next cycle; no done; avg_restart=0.
//  4. start held during a batch; start+abort together while IDLE
//     -> no restart of the batch; no state change, busy stays 0.
//  5. rst asserted while in WAIT_READY
//     -> all outputs 0 asynchronously; state IDLE after release.
//  6. (AVG_SCHED_TIMEOUT_EN) timeout_cycles=50, model never raises ready
//     -> error=1 after 50 cycles in WAIT_READY, busy=0, no done; the next start clears error.

Source files
------------

// File: rtl/avg_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : avg_sched_pkg
// Purpose  : Shared state encoding and default widths for averager_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package avg_sched_pkg;

    localparam int c_DEF_SLOW_COUNT_WIDTH = 19;
    localparam int c_DEF_RUN_COUNT_WIDTH  = 16;
    localparam int c_DEF_TIMEOUT_WIDTH    = 32;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ARM        = 2'd1,
        ST_WAIT_READY = 2'd2,
        ST_DONE       = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/avg_sched_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : avg_sched_watchdog
// Purpose  : Cycle counter that flags expiry when it reaches a non-zero limit.
// Revision : 1.0 - initial release
// ============================================================================
module avg_sched_watchdog #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // A zero limit disables the watchdog entirely.
    assign expired = (limit != '0) && (r_count == limit);

endmodule
`default_nettype wire

// File: rtl/averager_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : averager_scheduler
// Purpose  : Sequences averager_counter through N back-to-back runs per start
//            and reports per-run and batch completion.
// Options  : AVG_SCHED_TIMEOUT_EN adds the watchdog, timeout_cycles and error.
// Revision : 1.0 - initial release
// ============================================================================
module averager_scheduler
    import avg_sched_pkg::*;
#(
    parameter int SLOW_COUNT_WIDTH = c_DEF_SLOW_COUNT_WIDTH,
    parameter int RUN_COUNT_WIDTH  = c_DEF_RUN_COUNT_WIDTH,
    parameter int TIMEOUT_WIDTH    = c_DEF_TIMEOUT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [RUN_COUNT_WIDTH-1:0]  n_runs,
    input  logic                        avg_ready,
    input  logic [SLOW_COUNT_WIDTH-1:0] avg_n_avg,
    output logic                        avg_restart,
    output logic                        avg_clken,
    output logic                        busy,
    output logic [RUN_COUNT_WIDTH-1:0]  run_count,
    output logic [SLOW_COUNT_WIDTH-1:0] last_n_avg,
    output logic                        run_done,
    output logic                        done,
`ifdef AVG_SCHED_TIMEOUT_EN
    input  logic [TIMEOUT_WIDTH-1:0]    timeout_cycles,
`endif
    output logic                        error
);

    state_t                      r_state;
    state_t                      w_next_state;
    logic [RUN_COUNT_WIDTH-1:0]  r_n_runs;
    logic [RUN_COUNT_WIDTH-1:0]  r_run_count;
    logic [RUN_COUNT_WIDTH-1:0]  w_count_inc;
    logic [SLOW_COUNT_WIDTH-1:0] r_last_n_avg;
    logic                        r_busy;
    logic                        r_avg_restart;
    logic                        r_run_done;
    logic                        r_done;
    logic                        w_accept;
    logic                        w_run_end;
    logic                        w_last_run;
    logic                        w_expired;

    assign w_count_inc = r_run_count + RUN_COUNT_WIDTH'(1);
    // A latched n_runs of zero means continuous mode, so the wrap to zero never ends it.
    assign w_last_run  = (r_n_runs != '0) && (w_count_inc == r_n_runs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_run_end    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_ARM;
                end
            end
            ST_ARM: begin
                // ready is stale until it has fallen, so ARM never ends a run.
                if (abort || w_expired) begin
                    w_next_state = ST_IDLE;
                end else if (!avg_ready) begin
                    w_next_state = ST_WAIT_READY;
                end
            end
            ST_WAIT_READY: begin
                if (abort || w_expired) begin
                    w_next_state = ST_IDLE;
                end else if (avg_ready) begin
                    w_run_end    = 1'b1;
                    w_next_state = w_last_run ? ST_DONE : ST_ARM;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy        <= 1'b0;
            r_avg_restart <= 1'b0;
            r_run_done    <= 1'b0;
            r_done        <= 1'b0;
            r_n_runs      <= '0;
            r_run_count   <= '0;
            r_last_n_avg  <= '0;
        end else begin
            r_busy        <= (w_next_state != ST_IDLE);
            r_avg_restart <= (w_next_state == ST_ARM);
            r_run_done    <= w_run_end;
            r_done        <= (r_state == ST_DONE) && !abort;
            if (w_accept) begin
                r_n_runs    <= n_runs;
                r_run_count <= '0;
            end
            if (w_run_end) begin
                r_last_n_avg <= avg_n_avg;
                r_run_count  <= w_count_inc;
            end
        end
    end

`ifdef AVG_SCHED_TIMEOUT_EN
    logic w_in_run_state;
    logic w_wd_clear;
    logic w_wd_expired;
    logic r_error;

    assign w_in_run_state = (r_state == ST_ARM) || (r_state == ST_WAIT_READY);
    assign w_wd_clear     = (w_next_state != r_state) &&
                            ((w_next_state == ST_ARM) || (w_next_state == ST_WAIT_READY));
    assign w_expired      = w_wd_expired && w_in_run_state;

    avg_sched_watchdog #(
        .WIDTH (TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_wd_clear),
        .enable  (w_in_run_state),
        .limit   (timeout_cycles),
        .expired (w_wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_error <= 1'b0;
        end else if (w_accept) begin
            r_error <= 1'b0;
        end else if (w_expired) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign w_expired = 1'b0;

    // Without the watchdog nothing can raise error.
    if (TIMEOUT_WIDTH > 0) begin : g_no_watchdog
        assign error = 1'b0;
    end else begin : g_no_watchdog_zero_width
        assign error = 1'b0;
    end
`endif

    assign avg_restart = r_avg_restart;
    assign avg_clken   = r_busy;
    assign busy        = r_busy;
    assign run_count   = r_run_count;
    assign last_n_avg  = r_last_n_avg;
    assign run_done    = r_run_done;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_averager_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_averager_scheduler
// Purpose  : Randomised scoreboard bench for averager_scheduler with a simple
//            averager model; the watchdog case is built with AVG_SCHED_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_averager_scheduler;

    localparam int c_SW = 19;
    localparam int c_RW = 16;

    logic            clk;
    logic            rst;
    logic            start;
    logic            abort;
    logic [c_RW-1:0] n_runs;
    logic            avg_ready;
    logic [c_SW-1:0] avg_n_avg;
    logic            avg_restart;
    logic            avg_clken;
    logic            busy;
    logic [c_RW-1:0] run_count;
    logic [c_SW-1:0] last_n_avg;
    logic            run_done;
    logic            done;
    logic            error;
`ifdef AVG_SCHED_TIMEOUT_EN
    logic [31:0]     timeout_cycles;
`endif

    averager_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .n_runs         (n_runs),
        .avg_ready      (avg_ready),
        .avg_n_avg      (avg_n_avg),
        .avg_restart    (avg_restart),
        .avg_clken      (avg_clken),
        .busy           (busy),
        .run_count      (run_count),
        .last_n_avg     (last_n_avg),
        .run_done       (run_done),
        .done           (done),
`ifdef AVG_SCHED_TIMEOUT_EN
        .timeout_cycles (timeout_cycles),
`endif
        .error          (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit              is_done;
        int              cnt;
        logic [c_SW-1:0] navg;
    } exp_t;

    exp_t            exp_q[$];
    logic [c_SW-1:0] navg_q[$];
    logic [c_SW-1:0] last_val;
    int              checks = 0;
    int              passes = 0;
    int              cycle = 0;
    int              last_rd_cycle = 0;
    int              run_done_seen = 0;
    int              done_seen = 0;
    int              run_len_min = 20;
    int              run_len_max = 20;
    bit              model_stall = 1'b0;
    int              model_left;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic fail_event(input string name);
        checks++;
        $display("FAIL %s: got event/timeout expected none", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Averager model: restart drops ready, then ready returns after a random run length.
    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (rst) begin
            avg_ready  <= 1'b1;
            avg_n_avg  <= '0;
            model_left <= 0;
        end else if (avg_restart) begin
            avg_ready  <= 1'b0;
            model_left <= $urandom_range(run_len_max, run_len_min);
        end else if (!avg_ready && !model_stall) begin
            if (model_left <= 1) begin
                avg_ready <= 1'b1;
                avg_n_avg <= (navg_q.size() != 0) ? navg_q.pop_front() : '0;
            end else begin
                model_left <= model_left - 1;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b1) begin
            if (run_done === 1'b1) begin
                run_done_seen++;
                last_rd_cycle = cycle;
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    fail_event("unexpected_run_done");
                end else begin
                    e = exp_q.pop_front();
                    check("run_count", 64'(run_count), 64'(e.cnt));
                    check("last_n_avg", 64'(last_n_avg), 64'(e.navg));
                end
            end
            if (done === 1'b1) begin
                done_seen++;
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    fail_event("unexpected_done");
                end else begin
                    e = exp_q.pop_front();
                    check("done_run_count", 64'(run_count), 64'(e.cnt));
                    check("done_busy_low", 64'(busy), 64'(0));
                    check("done_spacing", 64'(cycle - last_rd_cycle), 64'(1));
                end
            end
        end
    end

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (busy !== 1'b0 && n < bound);
        if (busy !== 1'b0) fail_event("wait_idle_timeout");
    endtask

    task automatic wait_run_dones(input int target, input int bound);
        int n;
        n = 0;
        while (run_done_seen < target && n < bound) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (run_done_seen < target) fail_event("wait_run_done_timeout");
    endtask

    task automatic start_batch(input int nr, input int nexp, input bit exp_done,
                               input bit fixed_vals, input int hold);
        int              guard;
        exp_t            e;
        logic [c_SW-1:0] v;
        guard = 0;
        while (avg_ready !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        if (avg_ready !== 1'b1) fail_event("averager_idle_wait");
        navg_q.delete();
        for (int i = 0; i < nexp; i++) begin
            v = fixed_vals ? c_SW'(5 + 2 * i) : c_SW'($urandom_range(1, 19'h7FFFF));
            navg_q.push_back(v);
            e.is_done = 1'b0;
            e.cnt     = i + 1;
            e.navg    = v;
            exp_q.push_back(e);
            last_val = v;
        end
        if (exp_done) begin
            e.is_done = 1'b1;
            e.cnt     = nexp;
            e.navg    = last_val;
            exp_q.push_back(e);
        end
        tick();
        start  = 1'b1;
        n_runs = c_RW'(nr);
        tick();
        if (hold <= 1) start = 1'b0;
        n_runs = c_RW'($urandom);
        @(negedge clk);
        check("restart_latency", 64'(avg_restart), 64'(1));
        check("clken_in_arm", 64'(avg_clken), 64'(1));
        repeat (hold - 1) tick();
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang expected completion");
        $fatal(1);
    end

    initial begin
        int base;
        int guard;
        int cyc;
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        n_runs = '0;
`ifdef AVG_SCHED_TIMEOUT_EN
        timeout_cycles = '0;
`endif
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_restart", 64'(avg_restart), 64'(0));
        check("rst_clken", 64'(avg_clken), 64'(0));
        check("rst_run_count", 64'(run_count), 64'(0));
        check("rst_last_n_avg", 64'(last_n_avg), 64'(0));
        check("rst_pulses", 64'({run_done, done}), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        tick();
        rst = 1'b0;

        // Three fixed 20-cycle runs with n_avg 5, 7, 9.
        start_batch(3, 3, 1'b1, 1'b1, 1);
        wait_idle(400);
        check("batch1_drained", 64'(exp_q.size()), 64'(0));
        check("batch1_done_count", 64'(done_seen), 64'(1));

        // start held high through most of a batch must not restart it.
        start_batch(2, 2, 1'b1, 1'b0, 30);
        wait_idle(400);
        check("held_start_drained", 64'(exp_q.size()), 64'(0));

        // Random batch sizes and run lengths.
        run_len_min = 3;
        run_len_max = 12;
        for (int b = 0; b < 4; b++) begin
            int nr;
            nr = $urandom_range(1, 4);
            start_batch(nr, nr, 1'b1, 1'b0, 1);
            wait_idle(400);
            check("rand_batch_drained", 64'(exp_q.size()), 64'(0));
        end

        // Continuous mode: four runs, then abort.
        run_len_min = 5;
        base = run_done_seen;
        start_batch(0, 4, 1'b0, 1'b0, 1);
        wait_run_dones(base + 4, 400);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_restart", 64'(avg_restart), 64'(0));
        check("abort_clken", 64'(avg_clken), 64'(0));
        check("abort_run_count", 64'(run_count), 64'(4));
        check("abort_last_n_avg", 64'(last_n_avg), 64'(last_val));
        repeat (30) tick();
        check("abort_drained", 64'(exp_q.size()), 64'(0));

        // start and abort together while idle.
        tick();
        start  = 1'b1;
        abort  = 1'b1;
        n_runs = 16'd2;
        tick();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("start_abort_busy", 64'(busy), 64'(0));
        check("start_abort_restart", 64'(avg_restart), 64'(0));
        repeat (5) tick();
        check("start_abort_still_idle", 64'(busy), 64'(0));

        // Abort in the same cycle the run would end.
        base = run_done_seen;
        start_batch(0, 1, 1'b0, 1'b0, 1);
        wait_run_dones(base + 1, 400);
        guard = 0;
        while (avg_ready === 1'b1 && guard < 50) begin tick(); guard++; end
        while (avg_ready === 1'b0 && guard < 100) begin tick(); guard++; end
        if (guard >= 100) fail_event("ready_rise_wait");
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("race_busy", 64'(busy), 64'(0));
        check("race_run_done", 64'(run_done), 64'(0));
        check("race_run_count", 64'(run_count), 64'(1));
        check("race_last_n_avg", 64'(last_n_avg), 64'(last_val));
        repeat (5) tick();

        // Asynchronous reset while waiting for ready.
        run_len_min = 10;
        base = run_done_seen;
        start_batch(2, 2, 1'b1, 1'b0, 1);
        wait_run_dones(base + 1, 400);
        repeat (4) tick();
        #1;
        rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_restart_clken", 64'({avg_restart, avg_clken}), 64'(0));
        check("arst_run_count", 64'(run_count), 64'(0));
        check("arst_last_n_avg", 64'(last_n_avg), 64'(0));
        check("arst_pulses", 64'({run_done, done}), 64'(0));
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        navg_q.delete();
        repeat (3) tick();
        @(negedge clk);
        check("idle_after_reset", 64'(busy), 64'(0));
        start_batch(1, 1, 1'b1, 1'b0, 1);
        wait_idle(200);
        check("post_reset_drained", 64'(exp_q.size()), 64'(0));

`ifdef AVG_SCHED_TIMEOUT_EN
        // Watchdog: the averager never finishes.
        base = done_seen;
        timeout_cycles = 32'd50;
        guard = 0;
        while (avg_ready !== 1'b1 && guard < 200) begin tick(); guard++; end
        model_stall = 1'b1;
        navg_q.delete();
        tick();
        start  = 1'b1;
        n_runs = 16'd1;
        tick();
        start = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while (busy !== 1'b0 && cyc < 300);
        check("timeout_error", 64'(error), 64'(1));
        check("timeout_busy", 64'(busy), 64'(0));
        check("timeout_window", 64'(cyc >= 50 && cyc <= 58), 64'(1));
        check("timeout_no_done", 64'(done_seen), 64'(base));
        model_stall = 1'b0;
        timeout_cycles = '0;
        start_batch(1, 1, 1'b1, 1'b0, 1);
        check("error_cleared", 64'(error), 64'(0));
        wait_idle(200);
        check("timeout_drained", 64'(exp_q.size()), 64'(0));
`else
        cyc = 0;
        check("error_tied_low", 64'(error + cyc), 64'(0));
`endif

        repeat (3) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
